clock_mode_ctrl: RTL and testbench

Sequencing controller for the hour-display converter. It owns the display-mode state: local or world clock, the selected country (USA, England, Spain) and 12H/24H. Button pulses and a 1 Hz tick drive the state. Its registered outputs feed the converter's `world_clock`, `h24`, `usa`, `england` and `spain` inputs directly.

---
 rtl/clock_mode_ctrl.sv | 125 ++++++++++++
 tb/tb_clock_mode_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Display-mode sequencer for the hour-display converter: local/world clock, country, 12H/24H.
// Optional auto-rotation among countries is built only when CLOCK_MODE_AUTO_ROT_EN is defined.
module clock_mode_ctrl #(
    parameter int TIMEOUT_S = 30,
    parameter int ROT_S     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1hz,
    input  logic btn_mode,
    input  logic btn_h24,
    input  logic auto_rot,
    output logic world_clock,
    output logic h24,
    output logic usa,
    output logic england,
    output logic spain,
    output logic mode_chg
);

    typedef enum logic [1:0] {LOCAL, USA, ENG, SPA} state_t;

    localparam logic [7:0] TO_LIM  = 8'(TIMEOUT_S);
    localparam logic [7:0] ROT_LIM = 8'(ROT_S);

    state_t     state, state_nxt;
    logic [7:0] idle_cnt, idle_nxt;
    logic       h24_nxt;
    logic       is_world;
    logic       timeout_hit;
    logic       rot_hit;
    logic [4:0] outs_prev;

    function automatic state_t next_mode(input state_t s);
        case (s)
            LOCAL:   return USA;
            USA:     return ENG;
            ENG:     return SPA;
            default: return LOCAL;
        endcase
    endfunction

    // Rotation cycles countries only; LOCAL is never entered this way.
    function automatic state_t next_country(input state_t s);
        case (s)
            USA:     return ENG;
            ENG:     return SPA;
            SPA:     return USA;
            default: return s;
        endcase
    endfunction

    assign is_world    = (state != LOCAL);
    assign timeout_hit = is_world && tick_1hz && (TO_LIM != 8'd0) && (idle_cnt >= TO_LIM - 8'd1);

`ifdef CLOCK_MODE_AUTO_ROT_EN
    logic [7:0] rot_cnt, rot_nxt;

    assign rot_hit = is_world && auto_rot && tick_1hz && (rot_cnt >= ROT_LIM - 8'd1);

    always_comb begin
        rot_nxt = rot_cnt;
        if (btn_mode || btn_h24 || !auto_rot || !is_world || timeout_hit || rot_hit)
            rot_nxt = 8'd0;
        else if (tick_1hz && rot_cnt != 8'hff)
            rot_nxt = rot_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rot_cnt <= 8'd0;
        else        rot_cnt <= rot_nxt;
    end
`else
    logic unused_auto_rot;
    logic [7:0] unused_rot_lim;
    assign unused_auto_rot = auto_rot;
    assign unused_rot_lim  = ROT_LIM;
    assign rot_hit         = 1'b0;
`endif

    // Priority: mode button, then timeout, then rotation; h24 toggles independently.
    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        h24_nxt   = h24 ^ btn_h24;
        if (btn_mode)
            state_nxt = next_mode(state);
        else if (timeout_hit)
            state_nxt = LOCAL;
        else if (rot_hit)
            state_nxt = next_country(state);

        // A rotation step deliberately leaves the idle count running.
        if (btn_mode || btn_h24 || timeout_hit || !is_world)
            idle_nxt = 8'd0;
        else if (tick_1hz && idle_cnt != 8'hff)
            idle_nxt = idle_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOCAL;
            idle_cnt    <= 8'd0;
            world_clock <= 1'b0;
            h24         <= 1'b0;
            usa         <= 1'b0;
            england     <= 1'b0;
            spain       <= 1'b0;
            outs_prev   <= 5'd0;
            mode_chg    <= 1'b0;
        end else begin
            state       <= state_nxt;
            idle_cnt    <= idle_nxt;
            world_clock <= (state_nxt != LOCAL);
            h24         <= h24_nxt;
            usa         <= (state_nxt == USA);
            england     <= (state_nxt == ENG);
            spain       <= (state_nxt == SPA);
            // Compare against last cycle's outputs so the pulse lands one cycle after the change.
            outs_prev   <= {world_clock, h24, usa, england, spain};
            mode_chg    <= ({world_clock, h24, usa, england, spain} != outs_prev);
        end
    end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Scoreboard bench for clock_mode_ctrl: directed button/tick vectors, mode_chg-driven monitor.
module tb_clock_mode_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic tick_1hz = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_h24 = 1'b0;
    logic auto_rot = 1'b0;
    logic world_clock, h24, usa, england, spain, mode_chg;

    int checks = 0;
    int failures = 0;
    logic [4:0] sb[$];
    logic [4:0] prev_exp = 5'd0;

    // {world_clock, h24, usa, england, spain} after the second tick with auto_rot held
`ifdef CLOCK_MODE_AUTO_ROT_EN
    localparam logic [4:0] ROT2 = 5'b11010;
`else
    localparam logic [4:0] ROT2 = 5'b11100;
`endif

    clock_mode_ctrl #(.TIMEOUT_S(3), .ROT_S(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
        .btn_h24(btn_h24), .auto_rot(auto_rot), .world_clock(world_clock),
        .h24(h24), .usa(usa), .england(england), .spain(spain), .mode_chg(mode_chg)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {world_clock, h24, usa, england, spain};
    endfunction

    task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", nm, got, exp);
        end
    endtask

    // One-cycle input event, then immediate output check; changes are queued for the monitor.
    task automatic step(input logic m, input logic h, input logic t, input logic [4:0] exp, input string nm);
        @(negedge clk);
        btn_mode = m; btn_h24 = h; tick_1hz = t;
        @(negedge clk);
        btn_mode = 1'b0; btn_h24 = 1'b0; tick_1hz = 1'b0;
        chk(nm, {outs(), mode_chg}, {exp, 1'b0});
        if (exp != prev_exp) begin
            sb.push_back(exp);
            prev_exp = exp;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mode_chg) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL mode_chg_unexpected got=%b expected=no_pulse", outs());
            end else begin
                logic [4:0] e;
                e = sb.pop_front();
                if (outs() !== e) begin
                    failures++;
                    $display("FAIL mode_chg_outputs got=%b expected=%b", outs(), e);
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 chk("reset_async", {outs(), mode_chg}, 6'b0);
        repeat (2) @(negedge clk);
        chk("reset_held", {outs(), mode_chg}, 6'b0);
        rst_n = 1'b1;

        step(1, 0, 0, 5'b10100, "mode_usa");
        step(1, 0, 0, 5'b10010, "mode_eng");
        step(1, 0, 0, 5'b10001, "mode_spa");
        step(1, 0, 0, 5'b00000, "mode_local");
        step(0, 1, 0, 5'b01000, "h24_local");
        step(1, 0, 0, 5'b11100, "mode_usa_h24");
        step(0, 1, 0, 5'b10100, "h24_usa");

        step(1, 0, 0, 5'b10010, "to_eng");
        step(0, 0, 1, 5'b10010, "to_tick1");
        step(0, 0, 1, 5'b10010, "to_tick2");
        step(0, 0, 1, 5'b00000, "to_tick3_local");

        step(1, 0, 0, 5'b10100, "rs_usa");
        step(1, 0, 0, 5'b10010, "rs_eng");
        step(0, 0, 1, 5'b10010, "rs_tick1");
        step(0, 0, 1, 5'b10010, "rs_tick2");
        step(0, 1, 0, 5'b11010, "rs_h24");
        step(0, 0, 1, 5'b11010, "rs_tick3");
        step(0, 0, 1, 5'b11010, "rs_tick4");
        step(0, 0, 1, 5'b01000, "rs_tick5_local");

        step(1, 0, 0, 5'b11100, "co_usa");
        step(1, 0, 0, 5'b11010, "co_eng");
        step(1, 0, 0, 5'b11001, "co_spa");
        step(0, 0, 1, 5'b11001, "co_tick1");
        step(0, 0, 1, 5'b11001, "co_tick2");
        step(1, 0, 1, 5'b01000, "mode_vs_timeout");

        auto_rot = 1'b1;
        step(1, 0, 0, 5'b11100, "ar_usa");
        step(0, 0, 1, 5'b11100, "ar_tick1");
        step(0, 0, 1, ROT2,     "ar_tick2");
        step(0, 0, 1, 5'b01000, "ar_tick3_timeout");
        step(1, 0, 0, 5'b11100, "ar2_usa");
        step(0, 0, 1, 5'b11100, "ar2_tick1");
        step(1, 0, 1, 5'b11010, "mode_vs_rot");
        step(0, 0, 1, 5'b11010, "ar2_tick_after");
        auto_rot = 1'b0;
        step(0, 0, 1, 5'b11010, "ar_off_hold");
        step(1, 0, 0, 5'b11001, "rst_pre_spa");

        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_midop", {outs(), mode_chg}, 6'b0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_exp = 5'd0;
        step(1, 0, 0, 5'b10100, "first_after_reset");

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL mode_chg_missing got=%0d_pending expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
